dht11_sensor_emu: RTL and testbench
===================================

# dht11_sensor_emu

Synthesizable DHT11 sensor model: the responder end of the DHT11 single-wire protocol.

- Watches the open-drain `dht11_io` bus for a host start pulse.
- Answers with the standard response preamble and a 40-bit frame built from parallel humidity and temperature inputs.
- Sits beside the DHT11 host controller in loopback builds and on the bench, so the host can be exercised without a physical sensor.
- Runs on `hwclk` and derives its own 1 µs time base.

## Interface
- `CLK_PER_US`, 25: `hwclk` cycles per microsecond tick.
- `START_MIN_US`, 18000: minimum host low time accepted as a start request.
- `T_RESP_WAIT`, 30: µs from host release to sensor pull-low.
- `T_RESP_LOW`, 80: response low time, µs.
- `T_RESP_HIGH`, 80: response released (high) time, µs.
- `T_BIT_LOW`, 50: low time preceding every bit and the end marker, µs.
- `T_ZERO_HIGH`, 26: high time for a 0 bit, µs.
- `T_ONE_HIGH`, 70: high time for a 1 bit, µs.

Ports:
- `hwclk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `humidity` in 16: [15:8] integer byte, [7:0] decimal byte.
- `temperature` in 16: [15:8] integer byte, [7:0] decimal byte.
- `dht11_io` inout 1: open-drain bus; external pull-up.
- `busy` out 1: high from start-pulse qualification to end of frame.
- `frame_cnt` out 8: count of completed frames.

## Operation
- **Bus driving:** the block drives `dht11_io` only as `0`, or releases it as `z`. It never drives `1`.
- **Bus input:** `dht11_io` input passes through a 2-FF synchronizer. All decisions use the synchronized value.
- **Time base:** a tick pulses one `hwclk` cycle every `CLK_PER_US` cycles. All durations are counted in ticks. The µs counter is sized with `$clog2(START_MIN_US+1)`.

States:
- **IDLE:** bus released. Synchronized low → HOST_LOW, µs counter cleared.
- **HOST_LOW:** count ticks while low.
  - Bus goes high with count ≥ `START_MIN_US` → latch `humidity`/`temperature`, compute checksum, assert `busy` → RESP_WAIT.
  - Bus goes high with count below `START_MIN_US` → IDLE, no response.
  - The counter saturates; it does not wrap.
- **RESP_WAIT:** released for `T_RESP_WAIT` ticks → RESP_LOW.
- **RESP_LOW:** drive 0 for `T_RESP_LOW` → RESP_HIGH.
- **RESP_HIGH:** release for `T_RESP_HIGH` → BIT_LOW, bit index = 39.
- **BIT_LOW:** drive 0 for `T_BIT_LOW` → BIT_HIGH.
- **BIT_HIGH:** release for `T_ONE_HIGH` if the current frame bit is 1, else `T_ZERO_HIGH`.
  - Index > 0 → decrement index, go to BIT_LOW.
  - Index = 0 → END_LOW.
- **END_LOW:** drive 0 for `T_BIT_LOW`, then release. `frame_cnt` +1 (wraps 255→0), `busy` deasserts → IDLE.

Frame and bus rules:
- Frame order, MSB first on the wire: `humidity[15:8]`, `humidity[7:0]`, `temperature[15:8]`, `temperature[7:0]`, checksum.
- Checksum is the 8-bit sum of the four data bytes, carry discarded.
- Input changes after the latch do not affect the frame in flight.
- From RESP_WAIT through END_LOW, bus activity from the host is ignored.

## Timing
- Reset values: bus released (`z`), `busy`=0, `frame_cnt`=0, state IDLE, frame register 0.
- Reset mid-frame releases the bus immediately (asynchronous). The next start pulse must be a complete `START_MIN_US` low after reset deasserts.
- Input latency: 2 `hwclk` cycles synchronizer, plus up to 1 tick of quantization on every edge.
- Output edge accuracy: each driven or released interval lasts its parameter value × `CLK_PER_US` cycles, ±1 cycle.
- `busy` rises on the `hwclk` edge after the synchronized host release is seen. It falls on the same edge that releases the bus after END_LOW.

## Configuration
- `DHT11_ERR_INJECT_EN`
  - **Defined:** adds input port `err_inject` (1 bit). If `err_inject` is high when the frame is latched, checksum bit 0 is inverted for that frame.
  - **Undefined:** the port is absent and the checksum is always correct.

## Structure
- Package `dht11_pkg`:
  - state enum localparams.
  - Default timing constants, shared with the host controller.
  - Checksum function.
- Sub-module `dht11_us_tick`: parameter `CLK_PER_US`; ports `hwclk`, `rst`, `tick`. Counter generating the 1 µs tick.

## Test plan
- Host holds low 18 ms then releases, `humidity`=16'h3700, `temperature`=16'h1905:
  - Release for 30 µs, low 80 µs, high 80 µs.
  - Then 40 bits decoding 37 00 19 05 55.
  - `frame_cnt`=1.
- Host low 1 ms → no bus drive, `busy` stays 0, `frame_cnt` unchanged.
- `humidity`=`temperature`=16'hFFFF → all data bits have 70 µs highs; checksum byte 8'hFC.
- Change inputs to 16'h0000 during bit 10 → transmitted frame still carries the latched values.
- Assert `rst` during BIT_LOW → bus goes `z` asynchronously, `busy`=0. A following valid start yields a full frame.
- With `DHT11_ERR_INJECT_EN` and `err_inject`=1, inputs 16'h3700/16'h1905 → checksum byte 8'h54.

Source files
------------

// File: rtl/dht11_sensor_emu_pkg.sv
// dht11_pkg: shared definitions for the DHT11 sensor model and host controller.
//   - default protocol timing constants (microseconds) and clock ratio
//   - responder FSM state encoding
//   - frame checksum helper
package dht11_pkg;

  localparam int DHT11_CLK_PER_US   = 25;
  localparam int DHT11_START_MIN_US = 18000;
  localparam int DHT11_T_RESP_WAIT  = 30;
  localparam int DHT11_T_RESP_LOW   = 80;
  localparam int DHT11_T_RESP_HIGH  = 80;
  localparam int DHT11_T_BIT_LOW    = 50;
  localparam int DHT11_T_ZERO_HIGH  = 26;
  localparam int DHT11_T_ONE_HIGH   = 70;
  localparam int DHT11_FRAME_BITS   = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_WAIT,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht11_state_e;

  // 8-bit sum of the four data bytes; carry out is dropped.
  function automatic logic [7:0] dht11_checksum(input logic [15:0] hum,
                                                input logic [15:0] temp);
    return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// dht11_sensor_emu_if: parallel side of the DHT11 sensor model.
//   humidity[15:0]    : [15:8] integer byte, [7:0] decimal byte
//   temperature[15:0] : [15:8] integer byte, [7:0] decimal byte
//   busy              : response/frame in progress
//   frame_cnt[7:0]    : completed frame count (wraps)
//   err_inject        : only when DHT11_ERR_INJECT_EN is defined; corrupts
//                       checksum bit 0 of the frame latched while it is high
// master = the side supplying measurements, slave = the sensor model.
interface dht11_sensor_emu_if;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        busy;
  logic [7:0]  frame_cnt;
`ifdef DHT11_ERR_INJECT_EN
  logic        err_inject;

  modport master (output humidity, output temperature, output err_inject,
                  input busy, input frame_cnt);
  modport slave  (input humidity, input temperature, input err_inject,
                  output busy, output frame_cnt);
`else
  modport master (output humidity, output temperature,
                  input busy, input frame_cnt);
  modport slave  (input humidity, input temperature,
                  output busy, output frame_cnt);
`endif
endinterface

// File: rtl/dht11_sensor_emu_us_tick.sv
// dht11_us_tick: free-running divider producing a one-cycle tick every
// CLK_PER_US hwclk cycles (the 1 us time base).
//   hwclk : clock
//   rst   : asynchronous active-high reset
//   tick  : one-cycle pulse per microsecond
module dht11_us_tick #(
  parameter int CLK_PER_US = 25
) (
  input  logic hwclk,
  input  logic rst,
  output logic tick
);

  localparam int W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [W-1:0] cnt_q;
  logic         tick_q;

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == W'(CLK_PER_US - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: responder end of the DHT11 single-wire protocol.
// Detects a host start pulse on dht11_io, then answers with the response
// preamble and a 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, csum}.
//   hwclk    : clock
//   rst      : asynchronous active-high reset
//   bus      : dht11_sensor_emu_if.slave (humidity, temperature, busy,
//              frame_cnt, and err_inject when enabled)
//   dht11_io : open-drain bus, driven only as 0 or released (z)
// Optional feature macro: DHT11_ERR_INJECT_EN (checksum bit 0 inversion).
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US   = DHT11_CLK_PER_US,
  parameter int START_MIN_US = DHT11_START_MIN_US,
  parameter int T_RESP_WAIT  = DHT11_T_RESP_WAIT,
  parameter int T_RESP_LOW   = DHT11_T_RESP_LOW,
  parameter int T_RESP_HIGH  = DHT11_T_RESP_HIGH,
  parameter int T_BIT_LOW    = DHT11_T_BIT_LOW,
  parameter int T_ZERO_HIGH  = DHT11_T_ZERO_HIGH,
  parameter int T_ONE_HIGH   = DHT11_T_ONE_HIGH
) (
  input  logic              hwclk,
  input  logic              rst,
  dht11_sensor_emu_if.slave bus,
  inout  wire               dht11_io
);

  localparam int CNT_W = $clog2(START_MIN_US + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  logic         tick;
  dht11_state_e state_q, state_d;
  cnt_t         cnt_q, cnt_d;
  logic [5:0]   idx_q, idx_d;
  logic [39:0]  frame_q, frame_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic [1:0]   sync_q;
  logic         bus_s;
  logic         drive_low;
  logic         busy;
  cnt_t         last_cnt;
  logic         cnt_last;
  logic [7:0]   csum;

  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .hwclk (hwclk),
    .rst   (rst),
    .tick  (tick)
  );

  // Input synchronizer. Our own low drive is masked so the sampled line
  // reads idle-high the moment we release after END_LOW, instead of
  // looking like a fresh host pulse for two cycles.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], dht11_io | drive_low};
  end

  assign bus_s = sync_q[1];

  always_comb begin
    csum = dht11_checksum(bus.humidity, bus.temperature);
`ifdef DHT11_ERR_INJECT_EN
    csum[0] = csum[0] ^ bus.err_inject;
`endif
  end

  // Final tick count of the current timed interval.
  always_comb begin
    last_cnt = '0;
    case (state_q)
      ST_RESP_WAIT: last_cnt = cnt_t'(T_RESP_WAIT - 1);
      ST_RESP_LOW:  last_cnt = cnt_t'(T_RESP_LOW - 1);
      ST_RESP_HIGH: last_cnt = cnt_t'(T_RESP_HIGH - 1);
      ST_BIT_LOW,
      ST_END_LOW:   last_cnt = cnt_t'(T_BIT_LOW - 1);
      ST_BIT_HIGH:  last_cnt = frame_q[idx_q] ? cnt_t'(T_ONE_HIGH - 1)
                                              : cnt_t'(T_ZERO_HIGH - 1);
      default:      last_cnt = '0;
    endcase
  end

  assign cnt_last = tick && (cnt_q == last_cnt);

  // State register
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!bus_s) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (bus_s) begin
          cnt_d = '0;
          if (cnt_q >= cnt_t'(START_MIN_US)) begin
            state_d = ST_RESP_WAIT;
            frame_d = {bus.humidity, bus.temperature, csum};
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tick && (cnt_q != '1)) begin
          // saturate rather than wrap on very long host lows
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Timed response states; host activity is ignored here.
        if (cnt_last) begin
          cnt_d = '0;
          case (state_q)
            ST_RESP_WAIT: state_d = ST_RESP_LOW;
            ST_RESP_LOW:  state_d = ST_RESP_HIGH;
            ST_RESP_HIGH: begin
              state_d = ST_BIT_LOW;
              idx_d   = 6'(DHT11_FRAME_BITS - 1);
            end
            ST_BIT_LOW:   state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
              if (idx_q != '0) begin
                idx_d   = idx_q - 1'b1;
                state_d = ST_BIT_LOW;
              end else begin
                state_d = ST_END_LOW;
              end
            end
            ST_END_LOW: begin
              state_d     = ST_IDLE;
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
            default:      state_d = ST_IDLE;
          endcase
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output decode
  always_comb begin
    drive_low = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_RESP_LOW, ST_BIT_LOW, ST_END_LOW: begin
        drive_low = 1'b1;
        busy      = 1'b1;
      end
      ST_RESP_WAIT, ST_RESP_HIGH, ST_BIT_HIGH: busy = 1'b1;
      default: ;
    endcase
  end

  assign dht11_io      = drive_low ? 1'b0 : 1'bz;
  assign bus.busy      = busy;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Testbench for dht11_sensor_emu. Timing scaled to CLK_PER_US=2 and a
// 200 us minimum start pulse so full frames fit a short run; protocol
// interval parameters stay at their defaults.
module tb_dht11_sensor_emu;

  localparam int CPU      = 2;
  localparam int START_US = 200;
  localparam int LIM      = 400;

  typedef struct {
    logic [39:0] frame;
    logic [7:0]  cnt;
  } exp_t;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic host_low = 1'b0;
  wire  dht11_io;

  pullup (dht11_io);
  assign dht11_io = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emu_if ifc ();

  dht11_sensor_emu #(
    .CLK_PER_US   (CPU),
    .START_MIN_US (START_US)
  ) dut (
    .hwclk    (clk),
    .rst      (rst),
    .bus      (ifc),
    .dht11_io (dht11_io)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_chk       = 0;
  int   n_pass      = 0;
  int   frames_done = 0;
  int   mon_bit     = -1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo,
                         input longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d cycles, expected %0d..%0d", nm, act, lo, hi);
  endtask

  // Counts negedge samples for which the bus holds lvl, starting at the
  // current sample; leaves us on the first sample of the opposite level.
  task automatic measure(input logic lvl, output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (dht11_io === lvl && !to) begin
      n++;
      if (n >= LIM) to = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic start_pulse(input int low_us);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (low_us * CPU) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames_done < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("frames_done", longint'(frames_done), longint'(n));
  endtask

  task automatic push(input logic [39:0] f, input logic [7:0] c);
    exp_t e;
    e.frame = f;
    e.cnt   = c;
    sb_q.push_back(e);
  endtask

  // Monitor: decodes one response per queued expectation
  initial begin : monitor
    exp_t        e;
    int          n, vl, vh;
    bit          to, ab, bv;
    logic [39:0] got;
    forever begin
      while (sb_q.size() == 0) @(negedge clk);
      while (host_low !== 1'b1) @(negedge clk);
      while (host_low !== 1'b0) @(negedge clk);
      e   = sb_q.pop_front();
      got = '0;
      vl  = 0;
      vh  = 0;
      measure(1'b1, n, to);
      chk_rng("t_resp_wait", longint'(n), 30 * CPU, 30 * CPU + CPU + 4);
      ab = to;
      if (!ab) begin
        measure(1'b0, n, to);
        chk_rng("t_resp_low", longint'(n), 80 * CPU - 1, 80 * CPU + 1);
        ab = to;
      end
      if (!ab) begin
        measure(1'b1, n, to);
        chk_rng("t_resp_high", longint'(n), 80 * CPU - 1, 80 * CPU + 1);
        ab = to;
      end
      for (int b = 39; b >= 0; b--) begin
        mon_bit = b;
        if (!ab) begin
          measure(1'b0, n, to);
          if (n < 50 * CPU - 1 || n > 50 * CPU + 1) vl++;
          ab = to;
          if (!ab) begin
            measure(1'b1, n, to);
            bv     = (n > 48 * CPU);
            got[b] = bv;
            if (bv ? (n < 70 * CPU - 1 || n > 70 * CPU + 1)
                   : (n < 26 * CPU - 1 || n > 26 * CPU + 1)) vh++;
            ab = to;
          end
        end
      end
      mon_bit = -1;
      chk("bit_low_time_errs", longint'(vl), 0);
      chk("bit_high_time_errs", longint'(vh), 0);
      chk("frame_data", longint'(got[39:8]), longint'(e.frame[39:8]));
      chk("checksum", longint'(got[7:0]), longint'(e.frame[7:0]));
      chk("frame_aborted", longint'(ab), 0);
      if (!ab) begin
        measure(1'b0, n, to);
        chk_rng("t_end_low", longint'(n), 50 * CPU - 1, 50 * CPU + 1);
        chk("busy_after_frame", longint'(ifc.busy), 0);
        chk("frame_cnt", longint'(ifc.frame_cnt), longint'(e.cnt));
      end
      frames_done++;
    end
  end

  // Stimulus
  initial begin : stim
    int bv, dv, k;
    ifc.humidity    = 16'h0000;
    ifc.temperature = 16'h0000;
`ifdef DHT11_ERR_INJECT_EN
    ifc.err_inject  = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("rst_bus_released", longint'(dht11_io), 1);
    chk("rst_busy", longint'(ifc.busy), 0);
    chk("rst_frame_cnt", longint'(ifc.frame_cnt), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Basic frame
    ifc.humidity    = 16'h3700;
    ifc.temperature = 16'h1905;
    push(40'h37_00_19_05_55, 8'd1);
    start_pulse(250);
    wait_frames(1);

    // Too-short host pulse: no response
    bv = 0;
    dv = 0;
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (100 * CPU) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) bv++;
    end
    @(posedge clk);
    #1 host_low = 1'b0;
    repeat (400 * CPU) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) bv++;
      if (dht11_io !== 1'b1) dv++;
    end
    chk("short_busy_samples", longint'(bv), 0);
    chk("short_bus_driven_samples", longint'(dv), 0);
    chk("short_frame_cnt", longint'(ifc.frame_cnt), 1);

    // All-ones data
    ifc.humidity    = 16'hFFFF;
    ifc.temperature = 16'hFFFF;
    push(40'hFF_FF_FF_FF_FC, 8'd2);
    start_pulse(250);
    wait_frames(2);

    // Inputs change mid-frame
    ifc.humidity    = 16'h4A12;
    ifc.temperature = 16'h1B07;
    push(40'h4A_12_1B_07_7E, 8'd3);
    start_pulse(250);
    k = 0;
    while (mon_bit != 10 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_bit10", longint'(mon_bit), 10);
    ifc.humidity    = 16'h0000;
    ifc.temperature = 16'h0000;
    wait_frames(3);

    // Reset during BIT_LOW of the first bit
    ifc.humidity    = 16'h3700;
    ifc.temperature = 16'h1905;
    start_pulse(250);
    repeat (430) @(negedge clk);
    chk("abort_pre_bus_low", longint'(dht11_io), 0);
    chk("abort_pre_busy", longint'(ifc.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_bus_released", longint'(dht11_io), 1);
    chk("abort_busy", longint'(ifc.busy), 0);
    chk("abort_frame_cnt", longint'(ifc.frame_cnt), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    push(40'h37_00_19_05_55, 8'd1);
    start_pulse(250);
    wait_frames(4);

`ifdef DHT11_ERR_INJECT_EN
    ifc.err_inject = 1'b1;
    push(40'h37_00_19_05_54, 8'd2);
    start_pulse(250);
    wait_frames(5);
    ifc.err_inject = 1'b0;
`endif

    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
